// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// NOP_INSTR is only written when LOADER_NOP_FILL_EN is defined.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          LOADER_HOLD_W = 4;

endpackage

// File: rtl/imem_program_loader_hold_timer.sv
// Loadable down-counter for the reset-release guard delay.
// reach_zero flags the cycle whose clock edge takes the count from 1 to 0.
module loader_hold_timer
  import loader_pkg::*;
#(
  parameter int W = LOADER_HOLD_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         reach_zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign reach_zero = en && (count_reg == W'(1));

endmodule

// File: rtl/imem_program_loader.sv
// Boot loader: streams words into instruction memory from index 0, then
// releases the core from reset after a guard delay. Optional NOP fill of the
// remaining memory is enabled by defining LOADER_NOP_FILL_EN.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int REG_WIDTH   = 32,
  parameter int NUM_INST    = 128,
  parameter int HOLD_CYCLES = 4,
  localparam int AW         = $clog2(NUM_INST)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [REG_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 imem_we,
  output logic [AW-1:0]        imem_addr,
  output logic [REG_WIDTH-1:0] imem_wdata,
  output logic                 core_rstn,
  output logic                 done,
  output logic                 error,
  output logic [AW:0]          word_count
);

  loader_state_t state_reg, state_next;
  logic [AW-1:0] addr_reg;
  logic          transfer, overflow, addr_at_end, clear, hold_load, hold_expire;
  loader_state_t last_target;

  assign in_ready    = (state_reg == LOAD);
  assign core_rstn   = (state_reg == DONE);
  assign done        = (state_reg == DONE);
  assign error       = (state_reg == ERR);

  assign transfer    = in_valid && in_ready;
  assign overflow    = (word_count == (AW+1)'(NUM_INST));
  assign addr_at_end = (addr_reg == AW'(NUM_INST - 1));
  assign clear       = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign hold_load   = (state_next == HOLD) && (state_reg != HOLD);

`ifdef LOADER_NOP_FILL_EN
  // A program that already reaches the last index skips FILL entirely.
  assign last_target = addr_at_end ? HOLD : FILL;
`else
  assign last_target = HOLD;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (transfer) begin
          if (overflow)     state_next = ERR;
          else if (in_last) state_next = last_target;
        end
      end
`ifdef LOADER_NOP_FILL_EN
      FILL: if (addr_at_end) state_next = HOLD;
`endif
      HOLD: if (hold_expire) state_next = DONE;
      DONE: if (start) state_next = LOAD;
      default: state_next = state_reg;
    endcase
  end

  // The address saturates at the last index; only a session restart rewinds it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state_reg <= state_next;
      imem_we   <= 1'b0;
      if (clear) begin
        addr_reg   <= '0;
        word_count <= '0;
      end else if ((state_reg == LOAD) && transfer && !overflow) begin
        imem_we    <= 1'b1;
        imem_addr  <= addr_reg;
        imem_wdata <= in_data;
        word_count <= word_count + (AW+1)'(1);
        if (!addr_at_end) addr_reg <= addr_reg + AW'(1);
      end
`ifdef LOADER_NOP_FILL_EN
      else if (state_reg == FILL) begin
        imem_we    <= 1'b1;
        imem_addr  <= addr_reg;
        imem_wdata <= REG_WIDTH'(NOP_INSTR);
        if (!addr_at_end) addr_reg <= addr_reg + AW'(1);
      end
`endif
    end
  end

  loader_hold_timer #(.W(LOADER_HOLD_W)) u_hold_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load       (hold_load),
    .load_value (LOADER_HOLD_W'(HOLD_CYCLES)),
    .en         (state_reg == HOLD),
    .reach_zero (hold_expire)
  );

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Upstream boot stage for riscv_single_cycle_processor.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory from word 0.
- Holds the core in reset until loading completes, then releases it after a fixed guard delay.
- Lets the top-level bench and FPGA top load programs without $readmemh.

Parameters:
- REG_WIDTH, 32, instruction/data word width.
- NUM_INST, 128, instruction memory depth in words; must be a power of two ≥ 2.
- HOLD_CYCLES, 4, cycles between the final write and core_rstn rising; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset, synchronously deasserted externally.
- start  in  1  single-cycle pulse; begins a load session from IDLE or DONE.
- in_valid  in  1  source has a word on in_data.
- in_data  in  REG_WIDTH  instruction word.
- in_last  in  1  qualifies the final word of the program.
- in_ready  out  1  loader accepts a word this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  $clog2(NUM_INST)  word index, not a byte address.
- imem_wdata  out  REG_WIDTH  write data.
- core_rstn  out  1  active-low reset to the processor.
- done  out  1  high while the core runs a loaded program.
- error  out  1  sticky overflow flag.
- word_count  out  $clog2(NUM_INST)+1  number of words accepted this session.

Behaviour:
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rstn=0, done=0, error=0, word_count=0.
- Asynchronous reset at any time, including mid-LOAD, returns every output to its reset value immediately. Partially written memory is not cleared.
- States: IDLE, LOAD, FILL (feature only), HOLD, DONE, ERR.
- IDLE:
  - core_rstn=0, in_ready=0.
  - start → LOAD; word_count and the address counter clear.
- LOAD:
  - in_ready=1.
  - A transfer occurs on a cycle where in_valid & in_ready. Registered one-cycle-latency write: the next cycle asserts imem_we=1, imem_addr=previous counter, imem_wdata=in_data.
  - Each transfer increments the counter and word_count.
  - Transfer with in_last → HOLD, or FILL if the feature is enabled.
  - in_last without in_valid is ignored.
- Overflow:
  - A transfer while word_count==NUM_INST and in_last was not previously seen → ERR.
  - No write is issued for that word.
  - A last word landing at index NUM_INST-1 is legal.
- HOLD:
  - in_ready=0.
  - Down-counter loads HOLD_CYCLES on entry.
  - core_rstn rises on the cycle the counter reaches 0 → DONE.
  - The final imem write always completes before HOLD counts.
- DONE:
  - done=1, core_rstn=1.
  - start → core_rstn=0, done=0, counters clear, → LOAD (reload).
- ERR:
  - error=1, core_rstn=0, in_ready=0.
  - Exited only by rstn.
  - start is ignored.
- start arriving in LOAD, HOLD or FILL is ignored.
- The address counter wraps to 0 only via clear, never arithmetically.

Optional Feature:
- Macro LOADER_NOP_FILL_EN.
- Defined:
  - After the last word, enter FILL and write 32'h0000_0013 (addi x0,x0,0) to every remaining index up to NUM_INST-1, one per cycle, with in_ready=0.
  - Then → HOLD.
  - If the program already fills memory, FILL lasts 0 cycles.
- Undefined:
  - The FILL state and logic are absent.
  - Last word → HOLD directly.
  - Untouched memory keeps its prior contents.

Decomposition:
- Shared package loader_pkg holds:
  - loader_state_t enum (IDLE, LOAD, FILL, HOLD, DONE, ERR).
  - NOP_INSTR = 32'h0000_0013.
  - LOADER_HOLD_W = 4.
- One natural sub-module: loader_hold_timer. Loadable down-counter with zero flag, used for HOLD.

Test Plan:
- Load 3 words 0x00500293, 0x00600313, 0x00628333 (last on word 3):
  - Writes appear at idx 0, 1, 2 one cycle after each accept.
  - word_count=3.
  - core_rstn rises 4 cycles after the last write; done=1.
- Stall stimulus with in_valid toggling every other cycle: writes stay contiguous with no gaps in the index sequence, and no write occurs on non-transfer cycles.
- Stream 129 words with no in_last and NUM_INST=128:
  - 128 writes occur.
  - The 129th accept sets error=1 with no write.
  - core_rstn stays 0 through 20 further cycles of start pulses.
- Assert rstn=0 after 2 of 5 words: all outputs reset immediately. Then start plus 5 words loads from idx 0 normally.
- From DONE, pulse start and load 1 word 0x00000013:
  - core_rstn drops the same cycle start is seen.
  - Write goes to idx 0.
  - done returns after HOLD.
- LOADER_NOP_FILL_EN defined, 2-word program: idx 2..127 are written with 0x00000013 (126 writes) before HOLD begins.
